// File: rtl/multicycle_control.sv
// Multicycle RISC-style control FSM: sequences fetch, decode, load/store and
// R-type execution, and drives datapath selects, memory handshake and write enables.
//
// state     | meaning
// FETCH     | request instruction at pc; on mem_ready load IR and pc+4
// DECODE    | dispatch on op; precompute old_pc+imm
// MEM_ADR   | compute rd1+imm effective address
// MEM_READ  | load data request, wait for mem_ready
// MEM_WB    | write load data to register file
// MEM_WRITE | store request, wait for mem_ready
// EXEC_R    | register-register ALU operation
// ALU_WB    | write ALU result to register file
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_source,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_source,
  output logic [1:0] result_source,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    ALU_WB    = 4'd7
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  state_t cur_state, nxt_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= FETCH;
    else        cur_state <= nxt_state;
  end

  assign state = cur_state;

  always_comb begin
    nxt_state     = cur_state;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_source    = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_control   = 3'b111;
    imm_source    = 2'b00;
    result_source = 2'b00;
    retire        = 1'b0;
    illegal       = 1'b0;
    case (cur_state)
      FETCH: begin
        mem_req = 1'b1;
        // rst_n gating keeps the fetch-complete strobes quiet while held in reset
        if (mem_ready && rst_n) begin
          ir_write      = 1'b1;
          pc_write      = 1'b1;
          alu_src_b     = 2'b10;
          alu_control   = 3'b000;
          result_source = 2'b10;
          nxt_state     = DECODE;
        end
      end
      DECODE: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b01;
        alu_control = 3'b000;
        case (op)
          OP_LOAD, OP_STORE: nxt_state = MEM_ADR;
          OP_RTYPE:          nxt_state = EXEC_R;
          default: begin
            illegal   = 1'b1;
            nxt_state = FETCH;
          end
        endcase
      end
      MEM_ADR: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = 3'b000;
        if (op == OP_STORE) begin
          imm_source = 2'b01;
          nxt_state  = MEM_WRITE;
        end else begin
          nxt_state  = MEM_READ;
        end
      end
      MEM_READ: begin
        mem_req    = 1'b1;
        adr_source = 1'b1;
        if (mem_ready) nxt_state = MEM_WB;
      end
      MEM_WB: begin
        result_source = 2'b01;
        reg_write     = 1'b1;
        retire        = 1'b1;
        nxt_state     = FETCH;
      end
      MEM_WRITE: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        adr_source = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          nxt_state = FETCH;
        end
      end
      EXEC_R: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        nxt_state = ALU_WB;
        if (func3 == 3'b000)      alu_control = (func7 == 7'b0100000) ? 3'b001 : 3'b000;
        else if (func3 == 3'b111) alu_control = 3'b010;
      end
      ALU_WB: begin
        result_source = 2'b00;
        reg_write     = 1'b1;
        retire        = 1'b1;
        nxt_state     = FETCH;
      end
      default: nxt_state = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected cycle
// traces built from the instruction-level rules, with random waits and fields.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_source, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, imm_source, result_source;
  logic [2:0] alu_control;
  logic       retire, illegal;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func3(func3), .func7(func7),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_source(adr_source), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_source(imm_source),
    .result_source(result_source), .retire(retire), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  logic [22:0] obs;
  assign obs = {state, mem_req, mem_write, adr_source, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_control, imm_source, result_source, retire, illegal};

  typedef struct packed {
    logic        ready;
    logic [22:0] out;
  } step_t;

  step_t q[$];
  int nvec = 0;
  int nerr = 0;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;

  function automatic logic [22:0] mk(input int st, input bit mreq, input bit mw, input bit adr,
                                     input bit irw, input bit pcw, input bit rw, input int a,
                                     input int b, input int alu, input int imm, input int rs,
                                     input bit ret, input bit ill);
    return {st[3:0], mreq, mw, adr, irw, pcw, rw, a[1:0], b[1:0], alu[2:0], imm[1:0], rs[1:0], ret, ill};
  endfunction

  function automatic int rdec(input logic [2:0] f3, input logic [6:0] f7);
    if (f3 == 3'b000) return (f7 == 7'b0100000) ? 1 : 0;
    if (f3 == 3'b111) return 2;
    return 7;
  endfunction

  task automatic check(input string tag, input logic [22:0] o, input logic [22:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input logic r, input logic [22:0] v);
    step_t s;
    s.ready = r;
    s.out   = v;
    q.push_back(s);
  endtask

  // Expected cycle-by-cycle trace of one instruction, starting in FETCH.
  task automatic build(input logic [6:0] iop, input logic [2:0] f3, input logic [6:0] f7,
                       input int fw, input int mw);
    bit ld, st, rt;
    ld = (iop == LD); st = (iop == ST); rt = (iop == RT);
    q.delete();
    for (int i = 0; i < fw; i++) push(1'b0, mk(0,1,0,0,0,0,0,0,0,7,0,0,0,0));
    push(1'b1, mk(0,1,0,0,1,1,0,0,2,0,0,2,0,0));
    push(1'($urandom), mk(1,0,0,0,0,0,0,1,1,0,0,0,0,!(ld || st || rt)));
    if (ld || st) push(1'($urandom), mk(2,0,0,0,0,0,0,2,1,0,st,0,0,0));
    if (ld) begin
      for (int i = 0; i < mw; i++) push(1'b0, mk(3,1,0,1,0,0,0,0,0,7,0,0,0,0));
      push(1'b1, mk(3,1,0,1,0,0,0,0,0,7,0,0,0,0));
      push(1'($urandom), mk(4,0,0,0,0,0,1,0,0,7,0,1,1,0));
    end
    if (st) begin
      for (int i = 0; i < mw; i++) push(1'b0, mk(5,1,1,1,0,0,0,0,0,7,0,0,0,0));
      push(1'b1, mk(5,1,1,1,0,0,0,0,0,7,0,0,1,0));
    end
    if (rt) begin
      push(1'($urandom), mk(6,0,0,0,0,0,0,2,0,rdec(f3, f7),0,0,0,0));
      push(1'($urandom), mk(7,0,0,0,0,0,1,0,0,7,0,0,1,0));
    end
  endtask

  task automatic play(input string tag, input int n);
    step_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      mem_ready = s.ready;
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), obs, s.out);
      check($sformatf("%s_inv[%0d]", tag, i),
            23'({mem_write & ~mem_req, (int'(reg_write) + int'(ir_write) + int'(mem_write)) > 1}), 23'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input string tag, input logic [6:0] iop, input logic [2:0] f3,
                     input logic [6:0] f7, input int fw, input int mw);
    op = iop; func3 = f3; func7 = f7;
    build(iop, f3, f7, fw, mw);
    play(tag, 1000);
  endtask

  logic [22:0] rst_vec;
  logic [6:0]  rop;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_vec = mk(0,1,0,0,0,0,0,0,0,7,0,0,0,0);
    rst_n = 1'b0; op = LD; func3 = 3'b000; func7 = 7'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", obs, rst_vec);
      @(posedge clk);
    end
    #1;
    mem_ready = 1'b0;
    rst_n = 1'b1;
    q.delete();
    for (int i = 0; i < 10; i++) push(1'b0, rst_vec);
    play("idle", 10);

    run("load_nowait", LD, 3'b010, 7'b0, 0, 0);
    run("store_wait2", ST, 3'b010, 7'b0, 0, 2);
    run("r_add", RT, 3'b000, 7'b0000000, 0, 0);
    run("r_sub", RT, 3'b000, 7'b0100000, 0, 0);
    run("r_and", RT, 3'b111, 7'b0000000, 0, 0);
    run("r_none", RT, 3'b100, 7'b0000000, 0, 0);
    run("illegal", 7'b1111111, 3'b000, 7'b0, 0, 0);
    run("load_waits", LD, 3'b010, 7'b0, 2, 3);

    // Reset asserted while the load sits in MEM_READ.
    op = LD; func3 = 3'b010; func7 = 7'b0;
    build(LD, 3'b010, 7'b0, 0, 2);
    play("midload_pre", 3);
    check("midload_in_mem_read", 23'(state), 23'd3);
    mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("midload_abort", obs, rst_vec);
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("midload_held", obs, rst_vec);
      @(posedge clk);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("post_reset_load", LD, 3'b010, 7'b0, 1, 0);

    for (int n = 0; n < 40; n++) begin
      logic [2:0] f3;
      logic [6:0] f7;
      case ($urandom_range(0, 3))
        0: f3 = 3'b000;
        1: f3 = 3'b111;
        2: f3 = 3'($urandom);
        default: f3 = 3'b000;
      endcase
      f7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom);
      case ($urandom_range(0, 3))
        0: rop = LD;
        1: rop = ST;
        2: rop = RT;
        default: begin
          rop = 7'($urandom);
          while (rop == LD || rop == ST || rop == RT) rop = 7'($urandom);
        end
      endcase
      run($sformatf("rand%0d_op%b", n, rop), rop, f3, f7,
          $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
